sr_fetch: RTL

Instruction fetch stage of the schoolRISCV core. It sits directly upstream of the control decoder. It owns the program counter and issues word reads to instruction memory over a valid/ready request and in-order response interface. Fetched words are buffered in a 2-entry queue and presented to decode with a valid/ready handshake. On a taken branch, jump or jalr, the stage accepts a redirect, flushes the queue and discards any in-flight stale responses.

---
 rtl/sr_fetch_pkg.sv | 22 ++
 rtl/sr_cpu.svh | 9 +
 rtl/sr_fetch_fifo.sv | 65 ++++++
 rtl/sr_fetch.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sr_fetch_pkg.sv
// Types and constants shared by the fetch stage and its FIFO.
package sr_fetch_pkg;

`include "sr_cpu.svh"

  localparam int unsigned FetchDepth     = `FETCH_DEPTH;
  localparam logic [31:0] RvNop          = `RV_NOP;
  localparam logic [31:0] ResetPcDefault = `RESET_PC_DEFAULT;

  // Wide enough to hold 0..FetchDepth.
  typedef logic [1:0] cnt_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/sr_cpu.svh
// Shared schoolRISCV constants: canonical NOP, fetch queue depth and default reset PC.
`ifndef SR_CPU_SVH
`define SR_CPU_SVH

`define RV_NOP           32'h0000_0013
`define FETCH_DEPTH      2
`define RESET_PC_DEFAULT 32'h0000_0000

`endif

// File: rtl/sr_fetch_fifo.sv
// Two-entry FIFO with push/pop/flush and occupancy count. Flush wins over a same-cycle push.
module sr_fetch_fifo
  import sr_fetch_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output cnt_t             cnt_o
);

  logic [Width-1:0] mem_q [FetchDepth];
  logic [Width-1:0] mem_d [FetchDepth];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  cnt_t             cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop_i && (cnt_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    do_push  = push_i && ((cnt_q != cnt_t'(FetchDepth)) || do_pop);
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/sr_fetch.sv
// schoolRISCV instruction fetch: PC, credit-limited imem requests, 2-entry queue, redirect flush.
// Optional SR_FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise sticky fetch_misaligned.
module sr_fetch
  import sr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
`ifdef SR_FETCH_ALIGN_CHECK_EN
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
`else
  input  logic [31:0] redirect_pc
`endif
);

  logic [31:0]  pc_q, pc_d;
  cnt_t         drop_q, drop_d;
  cnt_t         tag_cnt, q_cnt;
  logic [31:0]  tag_pc;
  fetch_entry_t q_head, q_wdata;
  logic         accept, tag_pop, rsp_keep, pop, halt;
  logic [2:0]   credit;
  logic [31:0]  target_pc;

`ifdef SR_FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign halt             = misaligned_q;
  assign target_pc        = redirect_pc;
  assign fetch_misaligned = misaligned_q;
`else
  assign halt      = 1'b0;
  assign target_pc = word_align(redirect_pc);
`endif

  always_comb begin
    instr_valid = (q_cnt != '0) && !halt;
    pop         = instr_valid && instr_ready;
    // Slots promised to live requests; counting this cycle's pop sustains one fetch per cycle.
    credit      = {1'b0, tag_cnt} + {1'b0, q_cnt} - {2'b00, pop} - {1'b0, drop_q};
    imem_req    = !rst && !halt && (credit < 3'd2) && (tag_cnt != cnt_t'(FetchDepth));
    imem_addr   = pc_q;
    accept      = imem_req && imem_ready;
    tag_pop     = imem_rvalid && (tag_cnt != '0);
    rsp_keep    = tag_pop && (drop_q == '0) && !redirect_valid;
    q_wdata     = '{word: imem_rdata, pc: tag_pc};
    instr       = instr_valid ? q_head.word : RvNop;
    instr_pc    = instr_valid ? q_head.pc : '0;
  end

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = target_pc;
      // Everything still in flight after this cycle belongs to the old path.
      drop_d = tag_cnt + cnt_t'(accept) - cnt_t'(tag_pop);
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (tag_pop && (drop_q != '0)) begin
        drop_d = drop_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  sr_fetch_fifo #(
    .Width(32)
  ) u_tag_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept),
    .wdata_i(pc_q),
    .pop_i  (tag_pop),
    .flush_i(1'b0),
    .rdata_o(tag_pc),
    .cnt_o  (tag_cnt)
  );

  sr_fetch_fifo #(
    .Width($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (rsp_keep),
    .wdata_i(q_wdata),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .rdata_o(q_head),
    .cnt_o  (q_cnt)
  );

endmodule
